// File: rtl/riscv_m_pkg.sv
// riscv_m_pkg: RV32M FUNC3 encodings, muldiv FSM state encoding and operand helpers
package riscv_m_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  // rs1 is treated as signed by MULH, MULHSU and the signed divide/remainder ops
  function automatic logic a_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction
  function automatic logic b_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction
  function automatic logic is_rem(input logic [2:0] f3);
    return f3 inside {F3_REM, F3_REMU};
  endfunction
  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return s && v[31] ? -v : v;
  endfunction
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: ID/EX <-> muldiv handshake
// master = ID/EX side (drives START/FUNC3/operands), slave = muldiv unit (drives BUSY/RESULT/RESULT_VALID)
interface ex_muldiv_unit_if;
  logic        START;
  logic [2:0]  FUNC3;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic        BUSY;
  logic [31:0] RESULT;
  logic        RESULT_VALID;
  modport master (output START, FUNC3, OPERAND_A, OPERAND_B, input BUSY, RESULT, RESULT_VALID);
  modport slave (input START, FUNC3, OPERAND_A, OPERAND_B, output BUSY, RESULT, RESULT_VALID);
endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: 32-step restoring divider on unsigned magnitudes
// Ports: CLK, RESET; load_i, dividend_i, divisor_i in; quotient_o, remainder_o, done_o out
// quotient_o/remainder_o show the result of the step taken this cycle; done_o marks the final step
module muldiv_div_core (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);
  logic [31:0] r_q, q_q, d_q;
  logic [5:0] cnt_q;
  logic [32:0] sh, t;
  always_comb begin
    sh = {r_q, q_q[31]};
    t = sh - {1'b0, d_q};
    remainder_o = t[32] ? sh[31:0] : t[31:0];
    quotient_o = {q_q[30:0], ~t[32]};
    done_o = cnt_q == 6'd31;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      r_q <= '0;
      q_q <= dividend_i;
      d_q <= divisor_i;
      cnt_q <= '0;
    end else begin
      r_q <= remainder_o;
      q_q <= quotient_o;
      cnt_q <= done_o ? cnt_q : cnt_q + 6'd1;
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit in the EX stage
// Ports: CLK, RESET (sync, active-high); bus (slave): START, FUNC3, OPERAND_A, OPERAND_B in;
//        BUSY (combinational stall request), RESULT (held until next completion), RESULT_VALID (1-cycle pulse) out
module ex_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MUL_CYCLES = 2
) (
  input logic CLK,
  input logic RESET,
  ex_muldiv_unit_if.slave bus
);
  localparam logic [XLEN-1:0] MIN_INT = 32'h8000_0000;
  logic [1:0] state_q, state_d;
  logic [2:0] f3_q;
  logic [XLEN-1:0] a_q, b_q, result_q, result_d;
  logic [5:0] cnt_q, cnt_d;
  logic accept, sgn, dz, ovf, special, mul_last, div_done;
  logic [XLEN-1:0] spec_res, dq, dr, quo, rem, div_res, mul_res;
  logic [63:0] prod;
  muldiv_div_core u_div (
    .CLK(CLK),
    .RESET(RESET),
    .load_i(accept && bus.FUNC3[2]),
    .dividend_i(mag(bus.OPERAND_A, sgn)),
    .divisor_i(mag(bus.OPERAND_B, sgn)),
    .quotient_o(dq),
    .remainder_o(dr),
    .done_o(div_done)
  );
  always_comb begin
    accept = state_q == S_IDLE && bus.START;
    sgn = a_signed(bus.FUNC3);
    dz = bus.OPERAND_B == '0;
    ovf = sgn && bus.OPERAND_A == MIN_INT && bus.OPERAND_B == '1;
    special = bus.FUNC3[2] && (dz || ovf);
    spec_res = is_rem(bus.FUNC3) ? (dz ? bus.OPERAND_A : '0) : (dz ? '1 : MIN_INT);
    // sign-extending to 64 bits gives the exact 33x33 signed product modulo 2^64
    prod = {{32{b_signed(f3_q) & a_q[31] | a_signed(f3_q) & a_q[31]}}, a_q} * {{32{b_signed(f3_q) & b_q[31]}}, b_q};
    mul_res = f3_q == F3_MUL ? prod[31:0] : prod[63:32];
    quo = a_signed(f3_q) && (a_q[31] ^ b_q[31]) ? -dq : dq;
    rem = a_signed(f3_q) && a_q[31] ? -dr : dr;
    div_res = is_rem(f3_q) ? rem : quo;
    mul_last = state_q == S_MUL && cnt_q == 6'(MUL_CYCLES - 1);
    state_d = state_q == S_IDLE ? (bus.START ? (!bus.FUNC3[2] ? S_MUL : special ? S_DONE : S_DIV) : S_IDLE)
            : state_q == S_MUL ? (mul_last ? S_DONE : S_MUL)
            : state_q == S_DIV ? (div_done ? S_DONE : S_DIV)
            : S_IDLE;
    result_d = accept && special ? spec_res
             : mul_last ? mul_res
             : state_q == S_DIV && div_done ? div_res
             : result_q;
    cnt_d = accept ? '0 : state_q == S_MUL ? cnt_q + 6'd1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      result_q <= '0;
      cnt_q <= '0;
      f3_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      cnt_q <= cnt_d;
      if (accept) begin
        f3_q <= bus.FUNC3;
        a_q <= bus.OPERAND_A;
        b_q <= bus.OPERAND_B;
      end
    end
  end
  assign bus.BUSY = !RESET && (accept || state_q == S_MUL || state_q == S_DIV);
  assign bus.RESULT = result_q;
  assign bus.RESULT_VALID = state_q == S_DONE;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit with directed RV32M vectors
module tb_ex_muldiv_unit;
  localparam int MC = 2;
  localparam int LM = MC + 1;
  localparam int LD = 33;
  localparam int LS = 1;
  typedef struct {
    logic [31:0] r;
    int c;
    string n;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  ex_muldiv_unit_if bus();
  ex_muldiv_unit #(.XLEN(32), .MUL_CYCLES(MC)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.RESULT_VALID) begin
      if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.n, "_result"}, bus.RESULT, e.r);
        chk({e.n, "_cycle"}, 32'(cyc), 32'(e.c));
      end
    end
  end
  task automatic op(input string n, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] r, input int lat, input bit hold);
    int nb;
    @(negedge clk);
    bus.START = 1;
    bus.FUNC3 = f;
    bus.OPERAND_A = a;
    bus.OPERAND_B = b;
    q.push_back('{r, cyc + lat, n});
    nb = 0;
    #1;
    while (bus.BUSY && nb < 60) begin
      nb++;
      @(negedge clk);
      if (!hold) begin
        bus.START = 0;
        bus.FUNC3 = 3'($urandom);
        bus.OPERAND_A = $urandom;
        bus.OPERAND_B = $urandom;
      end
      #1;
    end
    chk({n, "_busy_cycles"}, 32'(nb), 32'(lat));
  endtask
  initial begin
    bus.START = 1;
    bus.FUNC3 = 3'b100;
    bus.OPERAND_A = 32'd9;
    bus.OPERAND_B = 32'd3;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("reset_valid", {31'd0, bus.RESULT_VALID}, 32'd0);
    chk("reset_result", bus.RESULT, 32'd0);
    bus.START = 0;
    rst = 0;
    @(negedge clk);
    chk("idle_busy", {31'd0, bus.BUSY}, 32'd0);
    op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LM, 0);
    op("mul_lo", 3'b000, 32'h12345678, 32'h10, 32'h23456780, LM, 0);
    op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LM, 0);
    op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LM, 0);
    op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LM, 0);
    op("mulhu_small", 3'b011, 32'h12345678, 32'h10, 32'h00000001, LM, 0);
    op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LD, 0);
    op("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LD, 0);
    op("div_negb", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, LD, 0);
    op("rem_negb", 3'b110, 32'd7, 32'hFFFFFFFE, 32'h00000001, LD, 0);
    op("divu", 3'b101, 32'd100, 32'd7, 32'd14, LD, 0);
    op("remu", 3'b111, 32'd100, 32'd7, 32'd2, LD, 0);
    op("divu_big", 3'b101, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, LD, 0);
    op("remu_big", 3'b111, 32'hFFFFFFFF, 32'h10, 32'h0000000F, LD, 0);
    op("divu_minint", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LD, 0);
    op("remu_minint", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LD, 0);
    op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, LS, 0);
    op("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, LS, 0);
    op("div_z", 3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, LS, 0);
    op("rem_z", 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, LS, 0);
    op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LS, 0);
    op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LS, 0);
    @(negedge clk);
    bus.START = 1;
    bus.FUNC3 = 3'b100;
    bus.OPERAND_A = 32'd1000;
    bus.OPERAND_B = 32'd3;
    @(negedge clk);
    bus.START = 0;
    repeat (9) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid_busy_during", {31'd0, bus.BUSY}, 32'd0);
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_mid_result", bus.RESULT, 32'd0);
    chk("rst_mid_valid", {31'd0, bus.RESULT_VALID}, 32'd0);
    rst = 0;
    repeat (30) @(negedge clk);
    op("b2b_first", 3'b101, 32'd100, 32'd7, 32'd14, LD, 1);
    op("b2b_second", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LD, 1);
    op("b2b_mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LM, 1);
    @(negedge clk);
    bus.START = 0;
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
